// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: seeds and self-synchronises to s[n] = s[n-TAP_HI] ^ s[n-TAP_LO],
// then free-runs a local generator to count bit errors and drops lock on an error burst.
module prbs_checker #(
  parameter int WIDTH      = 4,
  parameter int TAP_HI     = 4,
  parameter int TAP_LO     = 2,
  parameter int LOCK_COUNT = 8,
  parameter int WINDOW     = 16,
  parameter int LOSS_ERRS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_i,
  input  logic        bit_valid_i,
  input  logic        err_clr_i,
  output logic        locked_o,
  output logic        err_o,
  output logic [15:0] err_cnt_o
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hist, hist_nx;
  logic [SW-1:0]    seed_cnt, seed_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [WW-1:0]    win_cnt, win_nx;
  logic [EW-1:0]    win_err, werr_nx, werr_sum;
  logic             expected, bad;

  assign expected = hist[TAP_HI-1] ^ hist[TAP_LO-1];

  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    seed_nx  = seed_cnt;
    match_nx = match_cnt;
    win_nx   = win_cnt;
    werr_nx  = win_err;
    werr_sum = win_err;
    bad      = 1'b0;
    if (bit_valid_i) begin
      unique case (state)
        SEED: begin
          hist_nx = {hist[WIDTH-2:0], bit_i};
          seed_nx = seed_cnt + 1'b1;
          if (seed_cnt == SW'(WIDTH - 1)) begin
            state_nx = HUNT;
            seed_nx  = '0;
            match_nx = '0;
          end
        end
        HUNT: begin
          hist_nx = {hist[WIDTH-2:0], bit_i};
          // an all-zero history predicting a zero is not evidence of the sequence
          if (bit_i == expected && !(hist == '0 && !bit_i)) begin
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state_nx = LOCKED;
              match_nx = '0;
              win_nx   = '0;
              werr_nx  = '0;
            end else begin
              match_nx = match_cnt + 1'b1;
            end
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          // regenerate locally so one flipped bit is not fed back into the predictor
          hist_nx  = {hist[WIDTH-2:0], expected};
          bad      = (bit_i != expected);
          werr_sum = win_err + EW'(bad);
          if (werr_sum == EW'(LOSS_ERRS)) begin
            state_nx = SEED;
            hist_nx  = '0;
            seed_nx  = '0;
            win_nx   = '0;
            werr_nx  = '0;
          end else if (win_cnt == WW'(WINDOW - 1)) begin
            win_nx  = '0;
            werr_nx = '0;
          end else begin
            win_nx  = win_cnt + 1'b1;
            werr_nx = werr_sum;
          end
        end
        default: state_nx = SEED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked_o  <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state     <= state_nx;
      hist      <= hist_nx;
      seed_cnt  <= seed_nx;
      match_cnt <= match_nx;
      win_cnt   <= win_nx;
      win_err   <= werr_nx;
      locked_o  <= (state_nx == LOCKED);
      err_o     <= bad;
      if (err_clr_i)
        err_cnt_o <= '0;
      else if (bad && err_cnt_o != 16'hFFFF)
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a bit-list reference model is stepped alongside the DUT
// and compared every cycle, with literal expectations pinning the key events.
module tb_prbs_checker;
  localparam int WIDTH = 4, TAP_HI = 4, TAP_LO = 2, LOCK_COUNT = 8, WINDOW = 16, LOSS_ERRS = 4;

  logic        clk = 1'b0;
  logic        reset, bit_i, bit_valid_i, err_clr_i;
  logic        locked_o, err_o;
  logic [15:0] err_cnt_o;

  prbs_checker #(.WIDTH(WIDTH), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO), .LOCK_COUNT(LOCK_COUNT),
                 .WINDOW(WINDOW), .LOSS_ERRS(LOSS_ERRS)) dut (
    .clk(clk), .reset(reset), .bit_i(bit_i), .bit_valid_i(bit_valid_i), .err_clr_i(err_clr_i),
    .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // model: mode 0 collecting seed, 1 hunting, 2 locked; rx holds the recent bits, newest first
  int mode, nseed, run, wbits, werrs, m_cnt;
  bit m_lock, m_err;
  bit rx[$];
  bit pat[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int ph;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; nseed = 0; run = 0; wbits = 0; werrs = 0; m_cnt = 0;
    m_lock = 0; m_err = 0;
    rx.delete();
    for (int i = 0; i < WIDTH; i++) rx.push_back(1'b0);
  endtask

  task automatic model_step(bit b, bit v, bit clr);
    bit pred, allz;
    m_err = 0;
    if (v) begin
      pred = rx[TAP_HI-1] ^ rx[TAP_LO-1];
      allz = 1;
      foreach (rx[i]) if (rx[i]) allz = 0;
      if (mode == 0) begin
        rx.push_front(b); void'(rx.pop_back());
        nseed++;
        if (nseed == WIDTH) begin mode = 1; nseed = 0; run = 0; end
      end else if (mode == 1) begin
        rx.push_front(b); void'(rx.pop_back());
        run = (b == pred && !(allz && b == 0)) ? run + 1 : 0;
        if (run == LOCK_COUNT) begin mode = 2; run = 0; wbits = 0; werrs = 0; end
      end else begin
        rx.push_front(pred); void'(rx.pop_back());
        wbits++;
        if (b != pred) begin m_err = 1; werrs++; end
        if (werrs >= LOSS_ERRS) begin
          mode = 0; nseed = 0; wbits = 0; werrs = 0;
          foreach (rx[i]) rx[i] = 0;
        end else if (wbits == WINDOW) begin
          wbits = 0; werrs = 0;
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (m_err && m_cnt < 65535) m_cnt++;
    m_lock = (mode == 2);
  endtask

  // single compare point: drive, clock, advance the model, then sample 1ns after the edge
  task automatic step(bit b, bit v, bit clr);
    bit_i = b; bit_valid_i = v; err_clr_i = clr;
    @(posedge clk);
    model_step(b, v, clr);
    #1;
    chk("locked_o", locked_o, m_lock);
    chk("err_o", err_o, m_err);
    chk("err_cnt_o", err_cnt_o, m_cnt);
  endtask

  task automatic good(int n);
    for (int i = 0; i < n; i++) begin step(pat[ph], 1'b1, 1'b0); ph = (ph + 1) % 6; end
  endtask

  task automatic flip(bit clr);
    step(~pat[ph], 1'b1, clr); ph = (ph + 1) % 6;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; bit_i = 0; bit_valid_i = 0; err_clr_i = 0;
    model_reset();
    @(negedge clk);
    reset = 0;
    ph = 0;
  endtask

  initial begin
    reset = 1; bit_i = 0; bit_valid_i = 0; err_clr_i = 0;
    model_reset();
    #1;
    chk("reset locked_o", locked_o, 0);
    chk("reset err_o", err_o, 0);
    chk("reset err_cnt_o", err_cnt_o, 0);
    do_reset();

    // lock: 4 seed bits + 8 matching bits
    good(11);
    chk("unlocked after 11 bits", locked_o, 0);
    good(1);
    chk("locked after 12 bits", locked_o, 1);
    good(100);
    chk("clean run err_cnt", err_cnt_o, 0);

    // single error, counted once
    flip(1'b0);
    chk("single err_o", err_o, 1);
    chk("single err_cnt", err_cnt_o, 1);
    good(1);
    chk("single err_o one cycle", err_o, 0);
    good(19);
    chk("single lock held", locked_o, 1);
    chk("single no more errors", err_cnt_o, 1);

    // clear on an idle cycle, then a 4-error burst well inside one window
    step(1'b1, 1'b0, 1'b1);
    chk("idle clear", err_cnt_o, 0);
    flip(1'b0); flip(1'b0); flip(1'b0);
    chk("burst still locked", locked_o, 1);
    flip(1'b0);
    chk("loss locked_o", locked_o, 0);
    chk("loss err_cnt", err_cnt_o, 4);
    chk("loss err_o", err_o, 1);
    good(11);
    chk("relock not yet", locked_o, 0);
    good(1);
    chk("relocked", locked_o, 1);
    chk("relock keeps count", err_cnt_o, 4);

    // gaps with garbage on bit_i
    for (int i = 0; i < 30; i++) begin
      step(1'($urandom), 1'b0, 1'b0);
      good(1);
    end
    chk("gaps no errors", err_cnt_o, 4);
    chk("gaps locked", locked_o, 1);

    // clear on the same cycle as an error
    flip(1'b1);
    chk("clear+err err_cnt", err_cnt_o, 0);
    chk("clear+err err_o", err_o, 1);
    good(5);

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("async locked_o", locked_o, 0);
    chk("async err_cnt", err_cnt_o, 0);
    chk("async err_o", err_o, 0);
    model_reset();
    @(negedge clk);
    reset = 0;

    // all-zero stream never locks
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
    chk("all-zero unlocked", locked_o, 0);

    // lock again from a different phase after zeros
    ph = 3;
    good(40);
    chk("phase-shifted lock", locked_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Serial-side checker for the team's 4-bit LFSR pattern generator, the receive end of the PRBS link. It consumes one bit per valid cycle, self-synchronises to the recurrence s[n] = s[n-TAP_HI] ^ s[n-TAP_LO], and declares lock. Once locked it runs a local generator to count bit errors, and drops lock on excessive errors. It sits at the receive end of BIST and loopback paths.

Parameters:
WIDTH, 4, history length in bits and number of seed bits collected before checking.
TAP_HI, 4, older tap distance; 1..WIDTH.
TAP_LO, 2, newer tap distance; 1..TAP_HI-1.
LOCK_COUNT, 8, consecutive correct bits in HUNT required to lock.
WINDOW, 16, bits per error-monitoring window while LOCKED.
LOSS_ERRS, 4, errors within one window that force loss of lock.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
bit_i  in  1  received serial bit
bit_valid_i  in  1  bit_i qualifier; no state advances when low
err_clr_i  in  1  synchronous clear of err_cnt_o
locked_o  out  1  high while in LOCKED
err_o  out  1  one-cycle pulse, the cycle after an erroneous bit is sampled in LOCKED
err_cnt_o  out  16  saturating count of errors seen while LOCKED

Behaviour:
- One clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset (asserted at any time, including mid-operation):
  - state=SEED; history=0; all counters=0.
  - locked_o=0, err_o=0, err_cnt_o=0.
- All outputs are registered. Every action below occurs only on cycles with bit_valid_i=1.
- hist[0] is the newest bit. expected = hist[TAP_HI-1] ^ hist[TAP_LO-1].
- SEED:
  - Shift bit_i into hist; no comparison.
  - After WIDTH bits -> HUNT, with match_cnt=0.
- HUNT (self-synchronising):
  - Shift bit_i (the received bit) into hist.
  - Match (bit_i==expected) -> match_cnt+1.
  - Mismatch -> match_cnt=0.
  - Degenerate case: hist==0 with bit_i==0 is treated as a mismatch, so an all-zero stream never locks.
  - When match_cnt reaches LOCK_COUNT -> LOCKED. locked_o=1 the cycle after the LOCK_COUNT-th matching bit; win_cnt=0, win_err=0.
- LOCKED (free-running):
  - Shift expected (not bit_i) into hist, so a single flipped bit is counted exactly once.
  - bit_i!=expected -> err_o=1 next cycle; err_cnt_o+1, saturating at 16'hFFFF; win_err+1.
  - win_cnt+1 on every valid bit.
  - When win_cnt reaches WINDOW with win_err<LOSS_ERRS -> win_cnt=0, win_err=0.
  - win_err reaches LOSS_ERRS -> SEED, locked_o=0 next cycle, hist cleared. The error that triggers the loss is still counted and pulsed.
  - Loss takes priority over the window rollover on the same bit.
- err_clr_i:
  - Takes effect in any state and on any cycle, valid or not.
  - Clear wins over a simultaneous increment: err_cnt_o=0. err_o still pulses for that error.
  - Does not affect state, lock, or window counters.
- err_o is 0 in SEED and HUNT. err_cnt_o holds its value across loss of lock and relock; only reset or err_clr_i clears it.

Test Plan:
- Lock: reset, then feed the generator stream for seed 1110 (serial 0,1,1,1,1,0 repeating) with valid=1 every cycle -> locked_o rises the cycle after the 12th bit; err_o=0 and err_cnt_o=0 over 100 further bits.
- Single error: while locked, invert one bit -> exactly one err_o pulse one cycle later, err_cnt_o=1, lock held; the stream after the inverted bit raises no further errors.
- Loss: while locked, invert 4 bits within 16 -> err_cnt_o=4 and locked_o=0 the cycle after the 4th error; resuming a clean stream relocks after 12 bits, err_cnt_o still 4.
- All-zero: feed 50 zero bits after reset -> locked_o stays 0.
- Gaps and clear: while locked, interleave valid=0 cycles carrying garbage on bit_i -> no errors counted. Assert err_clr_i on the same cycle as an error bit -> err_cnt_o=0, err_o pulses.
- Async reset: assert reset mid-LOCKED with no clock edge -> locked_o=0 and err_cnt_o=0 immediately.
